// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder
// Memory-side responder for the LC-3b CPU memory interface. Latches one word
// request, waits a fixed LATENCY, then completes it with a one-cycle mem_resp.
// Holds a word-organised backing store with a byte-lane write mask and a
// backdoor preload port that is only honoured while idle.

module lc3b_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_byte_enable,
    input  logic [15:0]          mem_address,
    input  logic [15:0]          mem_wdata,
    output logic                 mem_resp,
    output logic [15:0]          mem_rdata,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [15:0]          init_data,
    output logic                 proto_err
);

    localparam int unsigned DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;

    // Latched request; authoritative once sampled
    logic                   r_op_wr;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [15:0]            r_wdata;
    logic [1:0]             r_be;

    // Registered outputs
    logic                   r_resp;
    logic [15:0]            r_rdata;
    logic                   r_perr;

    // Backing store (never reset)
    logic [15:0]            r_mem [DEPTH];

    logic                   w_req;
    logic                   w_sample;
    logic [ADDR_BITS-1:0]   w_in_idx;
    logic                   w_ld_is_read;
    logic [ADDR_BITS-1:0]   w_ld_idx;
    logic                   w_rd_load;
    logic                   w_commit;
    logic                   w_boot;
    logic                   w_st_we;
    logic [ADDR_BITS-1:0]   w_st_idx;
    logic [15:0]            w_st_data;
    logic [1:0]             w_st_mask;
    logic                   w_unused_addr;

    assign w_req    = mem_read | mem_write;
    assign w_sample = (r_state == ST_IDLE) && w_req;
    assign w_in_idx = mem_address[ADDR_BITS:1];

    // Bit 0 and the bits above the word index are don't-care (the store aliases)
    assign w_unused_addr = ^mem_address;

    // With LATENCY=1 the RESP-entry edge is also the sampling edge, so the read
    // index and op come straight from the bus instead of the latch.
    assign w_ld_is_read = (r_state == ST_IDLE) ? (mem_read & ~mem_write) : ~r_op_wr;
    assign w_ld_idx     = (r_state == ST_IDLE) ? w_in_idx : r_idx;
    assign w_rd_load    = (w_next == ST_RESP) && w_ld_is_read;

    // A write commits on the edge that leaves RESP; reset on that edge drops it
    assign w_commit = (r_state == ST_RESP) && r_op_wr && rst_n;
    assign w_boot   = (r_state == ST_IDLE) && !w_req && init_we;

    assign mem_resp  = r_resp;
    assign mem_rdata = r_rdata;
    assign proto_err = r_perr;

    // Next-state and wait-counter logic
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_cnt_next = CNT_LOAD;
                    w_next     = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_req) begin
                    w_next     = ST_IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt <= 4'd1) begin
                    w_next     = ST_RESP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request on the IDLE sampling edge; write wins over read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_sample) begin
            r_op_wr <= mem_write;
            r_idx   <= w_in_idx;
            r_wdata <= mem_wdata;
            r_be    <= mem_byte_enable;
        end
    end

    // Registered response strobe, read data and sticky protocol error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_resp <= (w_next == ST_RESP);
            if (w_rd_load) begin
                r_rdata <= r_mem[w_ld_idx];
            end
            if (w_sample && mem_read && mem_write) begin
                r_perr <= 1'b1;
            end
        end
    end

    // Single store write port: transaction commit or idle backdoor load
    always_comb begin
        w_st_we   = 1'b0;
        w_st_idx  = '0;
        w_st_data = '0;
        w_st_mask = '0;
        if (w_commit) begin
            w_st_we   = |r_be;
            w_st_idx  = r_idx;
            w_st_data = r_wdata;
            w_st_mask = r_be;
        end else if (w_boot) begin
            w_st_we   = 1'b1;
            w_st_idx  = init_addr;
            w_st_data = init_data;
            w_st_mask = 2'b11;
        end
    end

    // Byte-lane masked store update
    always_ff @(posedge clk) begin
        if (w_st_we) begin
            if (w_st_mask[0]) begin
                r_mem[w_st_idx][7:0] <= w_st_data[7:0];
            end
            if (w_st_mask[1]) begin
                r_mem[w_st_idx][15:8] <= w_st_data[15:8];
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: two instances (LATENCY=3 and LATENCY=1) driven
// by a CPU-like requester. The reference model is an edge-keyed schedule of
// expected outputs built from transaction-level rules.

module tb_lc3b_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  en;
    logic        mem_read, mem_write, init_we;
    logic [1:0]  be;
    logic [15:0] addr, wdata, init_data;
    logic [7:0]  init_addr;

    logic        rd0, wr0, iwe0, rd1, wr1, iwe1;
    logic        resp0, resp1, perr0, perr1;
    logic [15:0] rdata0, rdata1;

    assign rd0  = en[0] & mem_read;
    assign wr0  = en[0] & mem_write;
    assign iwe0 = en[0] & init_we;
    assign rd1  = en[1] & mem_read;
    assign wr1  = en[1] & mem_write;
    assign iwe1 = en[1] & init_we;

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_resp(resp0), .mem_rdata(rdata0), .init_we(iwe0),
        .init_addr(init_addr), .init_data(init_data), .proto_err(perr0)
    );

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_resp(resp1), .mem_rdata(rdata1), .init_we(iwe1),
        .init_addr(init_addr), .init_data(init_data), .proto_err(perr1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] data;
        logic [1:0]  be;
    } cm_t;

    int          errors = 0;
    int          checks = 0;
    int          edge_cnt = 0;
    bit          rst_seen = 0;
    logic [15:0] m_mem [2][256];
    logic [15:0] m_rdata [2];
    logic        m_perr [2];
    // keys are edge*2 + instance
    bit          resp_at [int];
    logic [15:0] rd_at [int];
    cm_t         cm_at [int];
    bit          perr_at [int];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, edge_cnt);
        end
    endtask

    // Apply scheduled effects at each rising edge
    always @(posedge clk) begin
        edge_cnt++;
        if (!rst_n) begin
            rst_seen = 1;
            for (int d = 0; d < 2; d++) begin
                m_rdata[d] = 16'h0000;
                m_perr[d]  = 1'b0;
            end
            resp_at.delete();
            rd_at.delete();
            cm_at.delete();
            perr_at.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                int  k;
                cm_t c;
                k = edge_cnt * 2 + d;
                if (rd_at.exists(k)) m_rdata[d] = rd_at[k];
                if (perr_at.exists(k)) m_perr[d] = 1'b1;
                if (cm_at.exists(k)) begin
                    c = cm_at[k];
                    if (c.be[0]) m_mem[d][c.idx][7:0]  = c.data[7:0];
                    if (c.be[1]) m_mem[d][c.idx][15:8] = c.data[15:8];
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_seen) begin
            int k;
            k = edge_cnt * 2;
            chk("resp0",  {15'b0, resp0}, {15'b0, resp_at.exists(k) ? 1'b1 : 1'b0});
            chk("rdata0", rdata0, m_rdata[0]);
            chk("perr0",  {15'b0, perr0}, {15'b0, m_perr[0]});
            chk("resp1",  {15'b0, resp1}, {15'b0, resp_at.exists(k + 1) ? 1'b1 : 1'b0});
            chk("rdata1", rdata1, m_rdata[1]);
            chk("perr1",  {15'b0, perr1}, {15'b0, m_perr[1]});
        end
    end

    // ---------------- stimulus tasks (start and end at a falling edge) ----------------
    task automatic preload(input logic [1:0] m, input logic [7:0] idx, input logic [15:0] data);
        en        = m;
        init_we   = 1'b1;
        init_addr = idx;
        init_data = data;
        for (int d = 0; d < 2; d++) if (m[d]) m_mem[d][idx] = data;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic txn(input int d, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] b, input bit noisy,
                       output int lat);
        int         L;
        int         s;
        logic [7:0] idx;
        bit         got;
        L   = (d == 1) ? 1 : 3;
        s   = edge_cnt + 1;
        idx = a[8:1];
        got = 0;
        lat = -1;
        en        = 2'(1 << d);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        be        = b;
        if (noisy) begin
            init_we   = 1'b1;
            init_addr = 8'($urandom);
            init_data = 16'($urandom);
        end
        if (wr) cm_at[(s + L) * 2 + d] = '{idx, wd, b};
        else    rd_at[(s + L - 1) * 2 + d] = m_mem[d][idx];
        if (rd && wr) perr_at[s * 2 + d] = 1'b1;
        resp_at[(s + L - 1) * 2 + d] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (d == 0) ? resp0 : resp1;
            if (got) begin
                lat = edge_cnt - s;
            end else if (noisy) begin
                addr      = 16'($urandom);
                wdata     = 16'($urandom);
                be        = 2'($urandom);
                init_addr = 8'($urandom);
                init_data = 16'($urandom);
            end
        end
        chk("resp_seen", {15'b0, got}, 16'h0001);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        init_we   = 1'b0;
        @(negedge clk);
    endtask

    // Instance 0 only: request dropped during the first BUSY cycle
    task automatic abort_txn(input bit rd, input logic [15:0] a, input logic [15:0] wd);
        en        = 2'b01;
        mem_read  = rd;
        mem_write = !rd;
        addr      = a;
        wdata     = wd;
        be        = 2'b11;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    // Instance 1 only: read held high continuously -> one response every 2 cycles
    task automatic b2b(input logic [15:0] a);
        int         s;
        logic [7:0] idx;
        s   = edge_cnt + 1;
        idx = a[8:1];
        en       = 2'b10;
        mem_read = 1'b1;
        addr     = a;
        for (int j = 0; j < 6; j += 2) begin
            resp_at[(s + j) * 2 + 1] = 1'b1;
            rd_at[(s + j) * 2 + 1]   = m_mem[1][idx];
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("b2b_resp", {15'b0, resp1}, (j % 2 == 0) ? 16'h0001 : 16'h0000);
        end
        mem_read = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          lat;
        int          d, op, gap;
        logic [15:0] ra, rw;
        logic [1:0]  rb;

        rst_n = 1'b0; en = 2'b00; mem_read = 1'b0; mem_write = 1'b0; init_we = 1'b0;
        be = 2'b00; addr = '0; wdata = '0; init_addr = '0; init_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_resp0",  {15'b0, resp0}, 16'h0000);
        chk("rst_rdata0", rdata0, 16'h0000);
        chk("rst_perr0",  {15'b0, perr0}, 16'h0000);
        chk("rst_resp1",  {15'b0, resp1}, 16'h0000);
        chk("rst_rdata1", rdata1, 16'h0000);
        chk("rst_perr1",  {15'b0, perr1}, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) preload(2'b11, 8'(i), 16'($urandom));
        preload(2'b11, 8'd5, 16'hBEEF);
        preload(2'b11, 8'd3, 16'h0000);

        // preload + read, LATENCY=3
        txn(0, 1, 0, 16'h000A, 16'h0000, 2'b00, 0, lat);
        chk("lat3", 16'(lat), 16'd2);
        chk("rd_beef", rdata0, 16'hBEEF);

        // byte lanes
        txn(0, 0, 1, 16'h000A, 16'h1234, 2'b01, 0, lat);
        txn(0, 1, 0, 16'h000A, 16'h0000, 2'b00, 0, lat);
        chk("be01", rdata0, 16'hBE34);
        txn(0, 0, 1, 16'h000A, 16'h5600, 2'b10, 0, lat);
        txn(0, 1, 0, 16'h000A, 16'h0000, 2'b00, 0, lat);
        chk("be10", rdata0, 16'h5634);
        txn(0, 0, 1, 16'h000A, 16'hFFFF, 2'b00, 0, lat);
        txn(0, 1, 0, 16'h000A, 16'h0000, 2'b00, 0, lat);
        chk("be00", rdata0, 16'h5634);

        // aliasing and bit 0
        txn(0, 0, 1, 16'h020B, 16'hCAFE, 2'b11, 0, lat);
        txn(0, 1, 0, 16'h000A, 16'h0000, 2'b00, 0, lat);
        chk("alias", rdata0, 16'hCAFE);

        // abort
        abort_txn(0, 16'h0006, 16'hAAAA);
        txn(0, 1, 0, 16'h0006, 16'h0000, 2'b00, 0, lat);
        chk("abort_word", rdata0, 16'h0000);

        // read+write together
        txn(0, 1, 1, 16'h000E, 16'h7777, 2'b11, 0, lat);
        chk("perr_set", {15'b0, perr0}, 16'h0001);
        chk("perr_rdata_held", rdata0, 16'h0000);
        txn(0, 1, 0, 16'h000E, 16'h0000, 2'b00, 0, lat);
        chk("perr_word", rdata0, 16'h7777);

        // reset during BUSY of a write
        en = 2'b01; mem_write = 1'b1; addr = 16'h000A; wdata = 16'h9999; be = 2'b11;
        @(negedge clk);
        rst_n = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_perr",  {15'b0, perr0}, 16'h0000);
        chk("rst_mid_rdata", rdata0, 16'h0000);
        txn(0, 1, 0, 16'h000A, 16'h0000, 2'b00, 0, lat);
        chk("rst_mid_word", rdata0, 16'hCAFE);

        // LATENCY=1
        txn(1, 1, 0, 16'h000A, 16'h0000, 2'b00, 0, lat);
        chk("lat1", 16'(lat), 16'd0);
        chk("rd1_beef", rdata1, 16'hBEEF);
        b2b(16'h000A);

        // randomized traffic on both instances
        for (int n = 0; n < 300; n++) begin
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            ra = 16'($urandom);
            rw = 16'($urandom);
            rb = 2'($urandom);
            if (op < 4)      txn(d, 1, 0, ra, rw, rb, $urandom_range(0, 1) == 1, lat);
            else if (op < 8) txn(d, 0, 1, ra, rw, rb, $urandom_range(0, 1) == 1, lat);
            else if (op < 9) txn(d, 1, 1, ra, rw, rb, $urandom_range(0, 1) == 1, lat);
            else if (d == 0) abort_txn($urandom_range(0, 1) == 1, ra, rw);
            else             preload(2'b10, ra[7:0], rw);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
